// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle ARM-subset core: sequences fetch/decode/execute/memory/writeback,
// owns the NZCV flag register and condition check, and gates architectural writes by the condition.
module multicycle_controller #(
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         Cond,
  input  logic [1:0]         Op,
  input  logic               Funct5,
  input  logic               Funct0,
  input  logic [3:0]         Rd,
  input  logic [3:0]         ALUFlags,
  input  logic [1:0]         FlagW,
  input  logic               NoWrite,
  output logic               PCWrite,
  output logic               MemWrite,
  output logic               RegWrite,
  output logic               IRWrite,
  output logic               AdrSrc,
  output logic [1:0]         ResultSrc,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic               ALUOp,
  output logic [1:0]         ImmSrc,
  output logic [1:0]         RegSrc,
  output logic [3:0]         Flags,
  output logic [STATE_W-1:0] State
);

  localparam logic [STATE_W-1:0] S_FETCH    = STATE_W'(0);
  localparam logic [STATE_W-1:0] S_DECODE   = STATE_W'(1);
  localparam logic [STATE_W-1:0] S_MEMADR   = STATE_W'(2);
  localparam logic [STATE_W-1:0] S_MEMRD    = STATE_W'(3);
  localparam logic [STATE_W-1:0] S_MEMWB    = STATE_W'(4);
  localparam logic [STATE_W-1:0] S_MEMWR    = STATE_W'(5);
  localparam logic [STATE_W-1:0] S_EXECUTER = STATE_W'(6);
  localparam logic [STATE_W-1:0] S_EXECUTEI = STATE_W'(7);
  localparam logic [STATE_W-1:0] S_ALUWB    = STATE_W'(8);
  localparam logic [STATE_W-1:0] S_BRANCH   = STATE_W'(9);

  logic [STATE_W-1:0] state, state_next;
  logic [3:0]         flags_q;
  logic               condex, condexr;
  logic               next_pc, regw, memw, branch, irw;
  logic               in_execute;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_FETCH;
    else        state <= state_next;
  end

  // Next-state logic; unused encodings fall back to FETCH
  always_comb begin
    state_next = S_FETCH;
    case (state)
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        case (Op)
          2'b00:   state_next = Funct5 ? S_EXECUTEI : S_EXECUTER;
          2'b01:   state_next = S_MEMADR;
          2'b10:   state_next = S_BRANCH;
          default: state_next = S_FETCH;
        endcase
      end
      S_MEMADR:   state_next = Funct0 ? S_MEMRD : S_MEMWR;
      S_MEMRD:    state_next = S_MEMWB;
      S_EXECUTER: state_next = S_ALUWB;
      S_EXECUTEI: state_next = S_ALUWB;
      default:    state_next = S_FETCH;
    endcase
  end

  // Per-state datapath controls and raw (ungated) write requests
  always_comb begin
    next_pc   = 1'b0;
    regw      = 1'b0;
    memw      = 1'b0;
    branch    = 1'b0;
    irw       = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ALUOp     = 1'b0;
    case (state)
      S_FETCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        irw       = 1'b1;
        next_pc   = 1'b1;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_MEMADR: ALUSrcB = 2'b01;
      S_MEMRD:  AdrSrc  = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        regw      = 1'b1;
      end
      S_MEMWR: begin
        AdrSrc = 1'b1;
        memw   = 1'b1;
      end
      S_EXECUTER: ALUOp = 1'b1;
      S_EXECUTEI: begin
        ALUSrcB = 2'b01;
        ALUOp   = 1'b1;
      end
      S_ALUWB: regw = 1'b1;
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        branch    = 1'b1;
      end
      default: ;
    endcase
  end

  // ARM condition evaluation against the architectural flags {N,Z,C,V}
  always_comb begin
    condex = 1'b1;
    case (Cond)
      4'b0000: condex = flags_q[2];
      4'b0001: condex = ~flags_q[2];
      4'b0010: condex = flags_q[1];
      4'b0011: condex = ~flags_q[1];
      4'b0100: condex = flags_q[3];
      4'b0101: condex = ~flags_q[3];
      4'b0110: condex = flags_q[0];
      4'b0111: condex = ~flags_q[0];
      4'b1000: condex = flags_q[1] & ~flags_q[2];
      4'b1001: condex = ~flags_q[1] | flags_q[2];
      4'b1010: condex = (flags_q[3] == flags_q[0]);
      4'b1011: condex = (flags_q[3] != flags_q[0]);
      4'b1100: condex = ~flags_q[2] & (flags_q[3] == flags_q[0]);
      4'b1101: condex = flags_q[2] | (flags_q[3] != flags_q[0]);
      default: condex = 1'b1;
    endcase
  end

  // Condition is frozen at end of DECODE so this instruction's own flag writes cannot affect it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                condexr <= 1'b0;
    else if (state == S_DECODE) condexr <= condex;
  end

  assign in_execute = (state == S_EXECUTER) || (state == S_EXECUTEI);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q <= 4'b0000;
    end else if (in_execute && condexr) begin
      if (FlagW[1]) flags_q[3:2] <= ALUFlags[3:2];
      if (FlagW[0]) flags_q[1:0] <= ALUFlags[1:0];
    end
  end

  // Write enables are also held low while reset is asserted (FETCH would otherwise request writes)
  assign RegWrite = reset & regw & condexr & ~((state == S_ALUWB) & NoWrite);
  assign MemWrite = reset & memw & condexr;
  assign PCWrite  = reset & (next_pc | (condexr & (branch | (regw & (Rd == 4'd15) & ~NoWrite))));
  assign IRWrite  = reset & irw;

  assign ImmSrc = Op;
  assign RegSrc = {Op == 2'b01, Op == 2'b10};
  assign Flags  = flags_q;
  assign State  = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed and random instructions compared against
// an instruction-level model that derives state sequences, write enables and flags from the ISA rules.
module tb_multicycle_controller;

  logic       clk, reset;
  logic [3:0] Cond, Rd, ALUFlags, Flags, State;
  logic [1:0] Op, FlagW, ResultSrc, ALUSrcB, ImmSrc, RegSrc;
  logic       Funct5, Funct0, NoWrite;
  logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA, ALUOp;

  int checks = 0;
  int errors = 0;
  logic [3:0] mflags;

  multicycle_controller #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct5(Funct5), .Funct0(Funct0),
    .Rd(Rd), .ALUFlags(ALUFlags), .FlagW(FlagW), .NoWrite(NoWrite),
    .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite), .IRWrite(IRWrite),
    .AdrSrc(AdrSrc), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .Flags(Flags), .State(State)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ARM condition table: even codes test a predicate, odd codes its inverse, 111x always
  function automatic bit cond_pass(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: return 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  task automatic check_cycle(input int s, input bit pass, input logic [3:0] rd, input bit nowr,
                             input logic [1:0] op);
    bit wb;
    logic [1:0] e_srcb, e_res;
    wb = (s == 4) || (s == 8);
    e_srcb = (s <= 1) ? 2'b10 : ((s == 2 || s == 7 || s == 9) ? 2'b01 : 2'b00);
    e_res  = (s <= 1 || s == 9) ? 2'b10 : ((s == 4) ? 2'b01 : 2'b00);
    chk("State",     8'(State),     8'(s));
    chk("IRWrite",   8'(IRWrite),   8'(s == 0));
    chk("PCWrite",   8'(PCWrite),   8'((s == 0) || (pass && ((s == 9) || (wb && rd == 4'd15 && !nowr)))));
    chk("RegWrite",  8'(RegWrite),  8'(pass && ((s == 4) || (s == 8 && !nowr))));
    chk("MemWrite",  8'(MemWrite),  8'(pass && (s == 5)));
    chk("AdrSrc",    8'(AdrSrc),    8'((s == 3) || (s == 5)));
    chk("ALUSrcA",   8'(ALUSrcA),   8'(s <= 1));
    chk("ALUSrcB",   8'(ALUSrcB),   8'(e_srcb));
    chk("ResultSrc", 8'(ResultSrc), 8'(e_res));
    chk("ALUOp",     8'(ALUOp),     8'((s == 6) || (s == 7)));
    chk("ImmSrc",    8'(ImmSrc),    8'(op));
    chk("RegSrc",    8'(RegSrc),    8'({op == 2'b01, op == 2'b10}));
    chk("Flags",     8'(Flags),     8'(mflags));
  endtask

  // Entered at a negedge with the DUT in FETCH; leaves at the negedge where the next FETCH begins
  task automatic run_instr(input logic [3:0] c, input logic [1:0] op, input bit f5, input bit f0,
                           input logic [3:0] rd, input logic [3:0] af, input logic [1:0] fw,
                           input bit nowr);
    int seq[$];
    bit pass;
    Cond = c; Op = op; Funct5 = f5; Funct0 = f0; Rd = rd; ALUFlags = af; FlagW = fw; NoWrite = nowr;
    pass = cond_pass(c, mflags);
    seq = '{0, 1};
    case (op)
      2'b00: begin seq.push_back(f5 ? 7 : 6); seq.push_back(8); end
      2'b01: begin seq.push_back(2); if (f0) begin seq.push_back(3); seq.push_back(4); end
                   else seq.push_back(5); end
      2'b10: seq.push_back(9);
      default: ;
    endcase
    foreach (seq[i]) begin
      #1;
      check_cycle(seq[i], pass, rd, nowr, op);
      if ((seq[i] == 6 || seq[i] == 7) && pass) begin
        if (fw[1]) mflags[3:2] = af[3:2];
        if (fw[0]) mflags[1:0] = af[1:0];
      end
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b1; Cond = 4'hE; Op = 2'b00; Funct5 = 1'b0; Funct0 = 1'b0; Rd = 4'd0;
    ALUFlags = 4'h0; FlagW = 2'b00; NoWrite = 1'b0; mflags = 4'h0;
    #1 reset = 1'b0;
    #1;
    chk("rst_state",   8'(State),    8'd0);
    chk("rst_flags",   8'(Flags),    8'd0);
    chk("rst_pcwrite", 8'(PCWrite),  8'd0);
    chk("rst_irwrite", 8'(IRWrite),  8'd0);
    @(posedge clk); #1;
    chk("rst_hold_state", 8'(State), 8'd0);
    @(negedge clk);
    reset = 1'b1;

    // ADD; SUBS Z=1 then BEQ taken; SUBS clears then BEQ not taken
    run_instr(4'hE, 2'b00, 0, 0, 4'd1, 4'h0, 2'b00, 0);
    run_instr(4'hE, 2'b01, 0, 1, 4'd2, 4'h0, 2'b00, 0);
    run_instr(4'hE, 2'b01, 0, 0, 4'd2, 4'h0, 2'b00, 0);
    run_instr(4'hE, 2'b00, 0, 1, 4'd3, 4'b0100, 2'b11, 0);
    chk("subs_flags", 8'(Flags), 8'h04);
    run_instr(4'h0, 2'b10, 1, 0, 4'd0, 4'h0, 2'b00, 0);
    run_instr(4'hE, 2'b00, 1, 1, 4'd3, 4'b0000, 2'b11, 0);
    run_instr(4'h0, 2'b10, 1, 0, 4'd0, 4'h0, 2'b00, 0);
    // CMP to r15 sets Z; STRNE suppressed; ADD to PC; flags survive into the reset test
    run_instr(4'hE, 2'b00, 0, 1, 4'd15, 4'b0110, 2'b11, 1);
    run_instr(4'h1, 2'b01, 0, 0, 4'd4, 4'h0, 2'b00, 0);
    run_instr(4'hE, 2'b00, 1, 0, 4'd15, 4'hF, 2'b00, 0);
    run_instr(4'hF, 2'b11, 0, 0, 4'd5, 4'h0, 2'b00, 0);

    // Asynchronous reset while in MEMRD
    Cond = 4'hE; Op = 2'b01; Funct5 = 1'b0; Funct0 = 1'b1; Rd = 4'd15; FlagW = 2'b00; NoWrite = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("pre_rst_state", 8'(State), 8'd3);
    chk("pre_rst_flags", 8'(Flags), 8'(mflags));
    reset = 1'b0;
    #1;
    mflags = 4'h0;
    chk("mid_rst_state",    8'(State),    8'd0);
    chk("mid_rst_flags",    8'(Flags),    8'd0);
    chk("mid_rst_pcwrite",  8'(PCWrite),  8'd0);
    chk("mid_rst_irwrite",  8'(IRWrite),  8'd0);
    chk("mid_rst_regwrite", 8'(RegWrite), 8'd0);
    chk("mid_rst_memwrite", 8'(MemWrite), 8'd0);
    @(posedge clk); #1;
    chk("mid_rst_hold", 8'(State), 8'd0);
    @(negedge clk);
    reset = 1'b1;
    run_instr(4'hE, 2'b01, 0, 1, 4'd6, 4'h0, 2'b00, 0);

    // Random instruction stream
    for (int i = 0; i < 200; i++) begin
      run_instr(4'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 4'($urandom),
                4'($urandom), 2'($urandom), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Main control unit for the multicycle ARM-subset processor: a state machine that sequences instruction fetch, decode, execute, memory access and writeback over the shared ALU/memory datapath. It owns the NZCV flag register and the condition check, and drives the ALU decoder's Op input (ALUOp). It consumes FlagW/NoWrite from the ALU decoder and gates all architectural writes by the instruction condition.

Parameters:
STATE_W, 4, width of the state register (10 states used)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
Cond  input  4  Instr[31:28], condition field
Op  input  2  Instr[27:26]; 00 data-processing, 01 memory, 10 branch
Funct5  input  1  Instr[25], immediate flag (I)
Funct0  input  1  Instr[20], S bit (DP) / L bit (memory)
Rd  input  4  Instr[15:12]
ALUFlags  input  4  {N,Z,C,V} from ALU, current cycle
FlagW  input  2  from ALU decoder; [1] write N,Z; [0] write C,V
NoWrite  input  1  from ALU decoder; CMP-class, suppress register write
PCWrite  output  1  PC register enable
MemWrite  output  1  data memory write enable
RegWrite  output  1  register file write enable
IRWrite  output  1  instruction register enable
AdrSrc  output  1  0 = PC, 1 = ALU result as memory address
ResultSrc  output  2  00 ALUOut, 01 Data, 10 ALUResult
ALUSrcA  output  1  0 = RD1 register, 1 = PC
ALUSrcB  output  2  00 RD2, 01 ExtImm, 10 constant 4
ALUOp  output  1  to ALU decoder Op: 0 force add, 1 decode Funct
ImmSrc  output  2  equals Op
RegSrc  output  2  [0] = (Op==10), [1] = (Op==01)
Flags  output  4  registered {N,Z,C,V}
State  output  4  current state, debug/verification

Behaviour:
- States: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9; codes 10-15 go to FETCH next cycle, all enables 0.
- Transitions: FETCH->DECODE; DECODE->MEMADR (Op=01), EXECUTEI (Op=00,Funct5=1), EXECUTER (Op=00,Funct5=0), BRANCH (Op=10), FETCH (Op=11); MEMADR->MEMRD (Funct0=1) else MEMWR; MEMRD->MEMWB; EXECUTER/EXECUTEI->ALUWB; MEMWB, MEMWR, ALUWB, BRANCH->FETCH.
- Cycle counts: DP 4, LDR 5, STR 4, B 3, undefined Op 2.
- Per-state outputs (unlisted = 0): FETCH AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUOp=0, ResultSrc=10, IRWrite=1, NextPC=1. DECODE ALUSrcA=1, ALUSrcB=10, ResultSrc=10. MEMADR ALUSrcB=01. MEMRD AdrSrc=1. MEMWB ResultSrc=01, RegW=1. MEMWR AdrSrc=1, MemW=1. EXECUTER ALUOp=1. EXECUTEI ALUSrcB=01, ALUOp=1. ALUWB RegW=1. BRANCH ALUSrcB=01, ResultSrc=10, Branch=1.
- CondEx from current Flags and Cond (ARM table, 0000 EQ..1101 LE); 1110 and 1111 always true. CondExR registered at end of DECODE; gates all writes for the rest of the instruction, so flag updates in EXECUTE never affect the same instruction.
- RegWrite = RegW & CondExR & ~(state==ALUWB & NoWrite).
- MemWrite = MemW & CondExR.
- PCWrite = NextPC | (CondExR & (Branch | (RegW & Rd==15 & ~NoWrite))).
- Flags: in EXECUTER/EXECUTEI only, if CondExR: FlagW[1] loads N,Z; FlagW[0] loads C,V from ALUFlags at clock edge.
- Reset (any cycle, including mid-instruction): State=FETCH, Flags=0000, CondExR=0 immediately (async); all write enables low while reset=0; first fetch on first rising edge after release.

Test Plan:
- Reset released, ADD (Cond=1110, Op=00, Funct5=0): states 0,1,6,8,0; RegWrite=1 only in ALUWB; PCWrite=1 only in FETCH.
- LDR (Op=01, Funct0=1): states 0,1,2,3,4,0; MEMRD AdrSrc=1; MEMWB ResultSrc=01, RegWrite=1; STR (Funct0=0): MEMWR MemWrite=1.
- SUBS with ALUFlags=0100, FlagW=11: Flags=0100 after EXECUTER; following BEQ (Cond=0000): BRANCH PCWrite=1; with Flags=0000 PCWrite=0.
- CMP (NoWrite=1, FlagW=11): Flags update, ALUWB RegWrite=0, PCWrite=0 even if Rd=15.
- ADD with Rd=15, Cond=1110: ALUWB RegWrite=1 and PCWrite=1; STR with Cond=0001, Z=1: MemWrite=0.
- reset=0 during MEMRD: State=0, Flags=0000 without clock edge; enables 0; refetch after release.
